// File: rtl/sprite_render_pipe.sv
// Sprite ROM address generation, palette decode and sword-swing animation sequencer.
// Optional horizontal mirroring is enabled by defining SPRITE_MIRROR_EN (adds port mirror_x).
module sprite_render_pipe #(
   parameter int unsigned SPRITE_W   = 32,
   parameter int unsigned SPRITE_H   = 32,
   parameter int unsigned IDX_W      = 3,
   parameter int unsigned FRAMES     = 4,
   parameter int unsigned FRAME_HOLD = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             frame_start,
   input  logic             attack,
   input  logic             pix_en,
   input  logic [9:0]       draw_x,
   input  logic [9:0]       draw_y,
   input  logic [9:0]       sprite_x,
   input  logic [9:0]       sprite_y,
`ifdef SPRITE_MIRROR_EN
   input  logic             mirror_x,
`endif
   output logic [9:0]       rom_address,
   output logic [1:0]       rom_frame_sel,
   input  logic [IDX_W-1:0] rom_q,
   output logic             pix_valid,
   output logic             pix_opaque,
   output logic [11:0]      pix_rgb,
   output logic             attacking
);

   localparam int unsigned XB = $clog2(SPRITE_W);
   localparam int unsigned YB = $clog2(SPRITE_H);
   localparam int unsigned FB = (FRAMES > 1) ? $clog2(FRAMES) : 1;
   localparam int unsigned HB = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

   typedef enum logic [1:0] {IDLE, SWING, COOLDOWN} state_t;

   state_t        state_q, state_d;
   logic [FB-1:0] frame_q, frame_d;
   logic [HB-1:0] hold_q, hold_d;
   logic [1:0]    rom_frame_sel_q, rom_frame_sel_d;
   logic          attacking_q, attacking_d;

   logic [9:0]    rom_address_q, rom_address_d;
   logic          tag_a_en_q, tag_a_en_d, tag_a_in_q, tag_a_in_d;
   logic          tag_b_en_q, tag_b_in_q;
   logic          pix_valid_q, pix_valid_d, pix_opaque_q, pix_opaque_d;
   logic [11:0]   pix_rgb_q, pix_rgb_d;

   logic [9:0]    dx_c, dy_c;
   logic [XB-1:0] col_c;
   logic [2:0]    idx_c;

   function automatic logic [11:0] palette(input logic [2:0] idx);
      case (idx)
         3'd1:    palette = 12'h000;
         3'd2:    palette = 12'hFFF;
         3'd3:    palette = 12'h0A0;
         3'd4:    palette = 12'h840;
         3'd5:    palette = 12'hFC9;
         3'd6:    palette = 12'hAAA;
         3'd7:    palette = 12'hF00;
         default: palette = 12'h000;
      endcase
   endfunction

   // Animation sequencer: every transition is gated by frame_start
   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      hold_d  = hold_q;
      if (frame_start) begin
         case (state_q)
            IDLE: begin
               if (attack) begin
                  state_d = SWING;
                  frame_d = '0;
                  hold_d  = '0;
               end
            end
            SWING: begin
               if (hold_q == HB'(FRAME_HOLD - 1)) begin
                  hold_d = '0;
                  if (frame_q == FB'(FRAMES - 1)) begin
                     state_d = COOLDOWN;
                     frame_d = '0;
                  end else begin
                     frame_d = frame_q + FB'(1);
                  end
               end else begin
                  hold_d = hold_q + HB'(1);
               end
            end
            COOLDOWN: begin
               if (!attack) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
      rom_frame_sel_d = (state_d == SWING) ? 2'(frame_d) : 2'b00;
      attacking_d     = (state_d == SWING);
   end

   // Pixel pipeline: address issue (A), ROM read (B), palette decode (C)
   always_comb begin
      dx_c  = draw_x - sprite_x;
      dy_c  = draw_y - sprite_y;
`ifdef SPRITE_MIRROR_EN
      col_c = dx_c[XB-1:0] ^ {XB{mirror_x}};
`else
      col_c = dx_c[XB-1:0];
`endif
      rom_address_d = 10'({dy_c[YB-1:0], col_c});
      tag_a_en_d    = pix_en;
      tag_a_in_d    = (dx_c < 10'(SPRITE_W)) && (dy_c < 10'(SPRITE_H));
      idx_c         = rom_q[2:0];
      pix_valid_d   = tag_b_en_q;
      pix_opaque_d  = tag_b_en_q && tag_b_in_q && (idx_c != 3'd0);
      pix_rgb_d     = pix_opaque_d ? palette(idx_c) : 12'h000;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         frame_q         <= '0;
         hold_q          <= '0;
         rom_frame_sel_q <= '0;
         attacking_q     <= 1'b0;
         rom_address_q   <= '0;
         tag_a_en_q      <= 1'b0;
         tag_a_in_q      <= 1'b0;
         tag_b_en_q      <= 1'b0;
         tag_b_in_q      <= 1'b0;
         pix_valid_q     <= 1'b0;
         pix_opaque_q    <= 1'b0;
         pix_rgb_q       <= '0;
      end else begin
         state_q         <= state_d;
         frame_q         <= frame_d;
         hold_q          <= hold_d;
         rom_frame_sel_q <= rom_frame_sel_d;
         attacking_q     <= attacking_d;
         rom_address_q   <= rom_address_d;
         tag_a_en_q      <= tag_a_en_d;
         tag_a_in_q      <= tag_a_in_d;
         tag_b_en_q      <= tag_a_en_q;
         tag_b_in_q      <= tag_a_in_q;
         pix_valid_q     <= pix_valid_d;
         pix_opaque_q    <= pix_opaque_d;
         pix_rgb_q       <= pix_rgb_d;
      end
   end

   assign rom_address   = rom_address_q;
   assign rom_frame_sel = rom_frame_sel_q;
   assign attacking     = attacking_q;
   assign pix_valid     = pix_valid_q;
   assign pix_opaque    = pix_opaque_q;
   assign pix_rgb       = pix_rgb_q;

endmodule

// File: tb/tb_sprite_render_pipe.sv
// Bench for sprite_render_pipe: synchronous ROM model, pixel expectation queue and
// a pulse-count model of the swing animation. Honours SPRITE_MIRROR_EN.
module tb_sprite_render_pipe;

   localparam int HOLD = 8;
   localparam int NFR  = 4;
`ifdef SPRITE_MIRROR_EN
   localparam bit MIRROR_ON = 1'b1;
`else
   localparam bit MIRROR_ON = 1'b0;
`endif

   logic        clock, reset_n, frame_start, attack, pix_en, mirror_x;
   logic [9:0]  draw_x, draw_y, sprite_x, sprite_y, rom_address;
   logic [1:0]  rom_frame_sel;
   logic [2:0]  rom_q;
   logic        pix_valid, pix_opaque, attacking;
   logic [11:0] pix_rgb;

   sprite_render_pipe dut (
      .clock(clock), .reset_n(reset_n), .frame_start(frame_start), .attack(attack),
      .pix_en(pix_en), .draw_x(draw_x), .draw_y(draw_y),
      .sprite_x(sprite_x), .sprite_y(sprite_y),
`ifdef SPRITE_MIRROR_EN
      .mirror_x(mirror_x),
`endif
      .rom_address(rom_address), .rom_frame_sel(rom_frame_sel), .rom_q(rom_q),
      .pix_valid(pix_valid), .pix_opaque(pix_opaque), .pix_rgb(pix_rgb),
      .attacking(attacking)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [2:0]  rom_mem [1024];
   logic [11:0] pal_tab [8];
   always @(posedge clock) rom_q <= rom_mem[rom_address];

   typedef struct {
      logic        v;
      logic        o;
      logic [11:0] rgb;
      logic [9:0]  addr;
   } exp_t;
   exp_t pq[$];

   int errors = 0;
   int checks = 0;
   int mode   = 0;
   int n      = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, expv);
      end
   endtask

   task automatic clear_pipe();
      exp_t z;
      z.v = 1'b0; z.o = 1'b0; z.rgb = 12'h000; z.addr = 10'd0;
      pq.delete();
      pq.push_back(z);
      pq.push_back(z);
   endtask

   // One clock: drive inputs, advance models, then check every output after the edge
   task automatic step(input logic fs, input logic atk, input logic pe,
                       input logic [9:0] dxin, input logic [9:0] dyin,
                       input logic [9:0] sx, input logic [9:0] sy, input logic mir);
      exp_t e;
      int   dx, dy, col;
      logic ins, mir_eff;
      frame_start = fs; attack = atk; pix_en = pe;
      draw_x = dxin; draw_y = dyin; sprite_x = sx; sprite_y = sy; mirror_x = mir;
      mir_eff = mir & MIRROR_ON;
      dx  = (int'(dxin) - int'(sx)) & 1023;
      dy  = (int'(dyin) - int'(sy)) & 1023;
      ins = (dx < 32) && (dy < 32);
      col = mir_eff ? 31 - (dx % 32) : dx % 32;
      e.addr = 10'((dy % 32) * 32 + col);
      e.v    = pe;
      e.o    = pe && ins && (rom_mem[e.addr] != 3'd0);
      e.rgb  = e.o ? pal_tab[rom_mem[e.addr]] : 12'h000;
      pq.push_back(e);
      if (fs) begin
         case (mode)
            0: if (atk) begin mode = 1; n = 0; end
            1: begin n++; if (n == NFR * HOLD) mode = 2; end
            default: if (!atk) mode = 0;
         endcase
      end
      @(posedge clock); #1;
      chk("rom_address", rom_address, e.addr);
      e = pq.pop_front();
      chk("pix_valid", pix_valid, e.v);
      chk("pix_opaque", pix_opaque, e.o);
      chk("pix_rgb", pix_rgb, e.rgb);
      chk("attacking", attacking, mode == 1);
      chk("rom_frame_sel", rom_frame_sel, (mode == 1) ? n / HOLD : 0);
   endtask

   task automatic rstep(input logic fs, input logic atk);
      logic [9:0] sx, sy;
      sx = 10'($urandom_range(0, 1000));
      sy = 10'($urandom_range(0, 1000));
      step(fs, atk, $urandom_range(0, 3) != 0,
           sx + 10'($urandom_range(0, 40)) - 10'd4,
           sy + 10'($urandom_range(0, 40)) - 10'd4,
           sx, sy, 1'($urandom));
   endtask

   task automatic pulse(input logic atk);
      rstep(1'b0, atk);
      rstep(1'b0, atk);
      rstep(1'b1, atk);
   endtask

   initial begin
      pal_tab = '{12'h000, 12'h000, 12'hFFF, 12'h0A0, 12'h840, 12'hFC9, 12'hAAA, 12'hF00};
      for (int i = 0; i < 1024; i++) rom_mem[i] = 3'($urandom);
      rom_mem[101] = 3'd2;
      rom_mem[330] = 3'd0;
      reset_n = 1'b0; frame_start = 1'b0; attack = 1'b0; pix_en = 1'b0; mirror_x = 1'b0;
      draw_x = '0; draw_y = '0; sprite_x = '0; sprite_y = '0;
      #12;
      chk("reset rom_address", rom_address, 0);
      chk("reset pix_valid", pix_valid, 0);
      chk("reset pix_rgb", pix_rgb, 0);
      chk("reset attacking", attacking, 0);
      chk("reset rom_frame_sel", rom_frame_sel, 0);
      @(negedge clock);
      reset_n = 1'b1;
      clear_pipe();

      // Directed pixels: known address, wrap below, right edge, transparent index
      step(0, 0, 1, 10'd105, 10'd53, 10'd100, 10'd50, 0);
      chk("directed address 101", rom_address, 101);
      step(0, 0, 1, 10'd99,  10'd53, 10'd100, 10'd50, 0);
      step(0, 0, 1, 10'd132, 10'd53, 10'd100, 10'd50, 0);
      step(0, 0, 1, 10'd110, 10'd60, 10'd100, 10'd50, 0);
      step(0, 0, 0, 10'd0,   10'd0,   10'd0,   10'd0, 0);
      step(0, 0, 0, 10'd0,   10'd0,   10'd0,   10'd0, 0);

      for (int i = 0; i < 200; i++) rstep(1'b0, 1'b0);

      // Full swing with attack held, then cooldown until release
      for (int p = 0; p < 40; p++) pulse(1'b1);
      pulse(1'b0);
      pulse(1'b0);
      // Second swing: release mid-swing must not abort, then reset during frame 2
      pulse(1'b1);
      for (int p = 0; p < 20; p++) pulse(1'b0);
      chk("frame 2 before reset", rom_frame_sel, 2);
      reset_n = 1'b0;
      #1;
      chk("async reset attacking", attacking, 0);
      chk("async reset rom_frame_sel", rom_frame_sel, 0);
      chk("async reset pix_valid", pix_valid, 0);
      @(negedge clock);
      reset_n = 1'b1;
      mode = 0; n = 0;
      clear_pipe();
      for (int i = 0; i < 6; i++) rstep(1'b0, 1'b0);

`ifdef SPRITE_MIRROR_EN
      step(0, 0, 1, 10'd105, 10'd53, 10'd100, 10'd50, 1);
      chk("mirror address 122", rom_address, 122);
      for (int i = 0; i < 100; i++) rstep(1'b0, 1'b0);
`endif
      step(0, 0, 0, 10'd0, 10'd0, 10'd0, 10'd0, 0);
      step(0, 0, 0, 10'd0, 10'd0, 10'd0, 10'd0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sprite_render_pipe.md
Name: sprite_render_pipe

Overview:
- Sits directly downstream of the 32x32 sword/character sprite ROMs. It drives their 10-bit address and consumes their palette-index output.
- Converts the VGA scan position (draw_x, draw_y) and the sprite's screen position into a ROM address, and absorbs the one-cycle ROM read latency.
- Decodes the palette index to 12-bit RGB with index 0 as transparent.
- Sequences the 4-frame sword-swing animation by selecting which ROM's output the top level muxes in.

Parameters:
- SPRITE_W, 32, sprite width in pixels (power of 2).
- SPRITE_H, 32, sprite height in pixels (power of 2).
- IDX_W, 3, ROM palette-index width.
- FRAMES, 4, animation frames per swing.
- FRAME_HOLD, 8, frame_start pulses each animation frame is held.

Ports:
- clock  in  1  system clock, shared with the sprite ROMs.
- reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse once per video frame (vsync edge).
- attack  in  1  level; player holds the attack key.
- pix_en  in  1  draw_x/draw_y valid this cycle.
- draw_x  in  10  current scan column.
- draw_y  in  10  current scan row.
- sprite_x  in  10  sprite top-left column.
- sprite_y  in  10  sprite top-left row.
- rom_address  out  10  address to the sprite ROM(s).
- rom_frame_sel  out  2  selects sword frame ROM 1..4 (encoded 0..3).
- rom_q  in  IDX_W  palette index returned by the selected ROM.
- pix_valid  out  1  output pixel corresponds to a pix_en input.
- pix_opaque  out  1  sprite covers this pixel (inside box and index != 0).
- pix_rgb  out  12  {R[3:0], G[3:0], B[3:0]}; 0 when not opaque.
- attacking  out  1  high while in state SWING.

Behaviour:
- **Reset.** Asynchronous on reset_n low. All outputs, pipeline registers, state, frame and hold counters go to 0; state = IDLE.
- **Pipeline timing.** The pipeline advances every clock with no stall.
  - Stage A, at edge E0: dx = draw_x - sprite_x and dy = draw_y - sprite_y, 10-bit unsigned.
  - inside = (dx < SPRITE_W) && (dy < SPRITE_H). A negative difference wraps to a large value and therefore counts as outside.
  - rom_address <= {dy[4:0], dx[4:0]}, i.e. dy*32 + dx. It is registered every cycle, including when inside = 0.
  - pix_en and inside are registered into tag A.
  - Stage B, at edge E1: the ROM samples rom_address. Tag A moves to tag B.
  - Stage C, at edge E2: rom_q is valid. pix_valid <= tag B pix_en. pix_opaque <= tag B pix_en & inside & (rom_q != 0). pix_rgb <= palette(rom_q) if opaque, else 0.
  - Total latency is 2 clocks from input sample to output.
- **Palette.** Fixed mapping from index to pix_rgb:
  - 1 = 0x000
  - 2 = 0xFFF
  - 3 = 0x0A0
  - 4 = 0x840
  - 5 = 0xFC9
  - 6 = 0xAAA
  - 7 = 0xF00
  - Index 0 is transparent. Bits of rom_q above 3 are ignored.
- **Animation FSM.** All transitions happen only on cycles with frame_start = 1.
  - IDLE: if attack = 1, go to SWING with frame = 0 and hold = 0.
  - SWING: each frame_start increments hold.
    - When hold == FRAME_HOLD-1, hold = 0.
    - If frame == FRAMES-1, go to COOLDOWN; otherwise frame = frame + 1.
  - COOLDOWN: go to IDLE when attack = 0. Attack must be released before another swing can start (no auto-repeat).
- **FSM outputs.** rom_frame_sel is registered and equals frame in SWING, 0 otherwise. It therefore changes only right after frame_start, so there is no mid-frame tearing. attacking = (state == SWING).
- **Simultaneous events.** Releasing attack during SWING does not abort the swing. A frame_start coincident with pix_en does not disturb the pixel pipeline.
- **Reset mid-swing.** Returns to IDLE immediately. rom_frame_sel = 0 and pix_valid = 0 on the next cycle after release.

Optional Feature:
- Macro: SPRITE_MIRROR_EN.
- When defined:
  - An extra input port mirror_x (1 bit) exists.
  - When mirror_x is sampled 1 in stage A, the address column is (SPRITE_W-1-dx), so right-facing ROMs render as left-facing.
  - inside is unaffected.
  - mirror_x travels with its pixel through the pipeline and never affects an already-issued address.
- When undefined: the port is absent and the column is always dx.

Test Plan:
- **Address and latency.** sprite_x = 100, sprite_y = 50, draw_x = 105, draw_y = 53, pix_en = 1 → rom_address = 101 after E0. ROM model returns 2 → pix_valid = 1, pix_opaque = 1, pix_rgb = 0xFFF exactly 2 clocks after the sample.
- **Outside / wrap.** draw_x = 99 (dx wraps to 1023) or draw_x = 132 → pix_opaque = 0, pix_rgb = 0, pix_valid = 1.
- **Transparency.** Inside pixel with rom_q = 0 → pix_opaque = 0, pix_rgb = 0.
- **Swing sequence.** attack held with FRAME_HOLD = 8 → rom_frame_sel goes 0,1,2,3 with each value lasting 8 frame_starts. Then COOLDOWN, attacking = 0. It stays in COOLDOWN until attack = 0 is seen on a frame_start, then IDLE.
- **Reset mid-swing.** reset_n pulsed low during frame 2 → attacking = 0, rom_frame_sel = 0, pix_valid = 0 asynchronously.
- **Mirror (SPRITE_MIRROR_EN).** dx = 5, dy = 3, mirror_x = 1 → rom_address = 3*32 + 26 = 122.
